// File: rtl/vga_pkg.sv
// vga_pkg
// Shared types and constants for the VGA framebuffer arbiter.
//   host_state_e : host command FSM states (H_IDLE, H_WAIT, H_RET)
//   ret_tag_e    : source id carried down the read-return pipeline
//   PRIO_*       : fixed arbitration ranks, 0 is the highest priority
//   pick_source  : resolves pending requests into the winning source
package vga_pkg;

    typedef enum logic [1:0] {
        H_IDLE = 2'd0,
        H_WAIT = 2'd1,
        H_RET  = 2'd2
    } host_state_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2,
        TAG_CLR  = 2'd3
    } ret_tag_e;

    localparam int PRIO_DISP   = 0;
    localparam int PRIO_HOST   = 1;
    localparam int PRIO_CLR    = 2;
    localparam int PRIO_LOWEST = 2;

    // Walk the ranks from lowest to highest priority so the last pending
    // source seen (the highest-ranked one) is the winner.
    function automatic ret_tag_e pick_source(input logic disp_pend,
                                             input logic host_pend,
                                             input logic clr_pend);
        ret_tag_e win;
        win = TAG_NONE;
        for (int r = PRIO_LOWEST; r >= 0; r--) begin
            if (r == PRIO_CLR  && clr_pend)  win = TAG_CLR;
            if (r == PRIO_HOST && host_pend) win = TAG_HOST;
            if (r == PRIO_DISP && disp_pend) win = TAG_DISP;
        end
        return win;
    endfunction

endpackage

// File: rtl/vga_fb_arbiter_mod_counter.sv
// vga_fb_arbiter_mod_counter
// Modulo-MOD up counter with clock enable.
//   clk, rst  : clock, synchronous active-high reset (count -> 0)
//   cen       : advance by one this cycle
//   count     : current value, 0..MOD-1
//   sync_ovf  : high in the cycle cen advances count from MOD-1 back to 0
module vga_fb_arbiter_mod_counter #(
    parameter int MOD = 16,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    output logic [W-1:0] count,
    output logic         sync_ovf
);

    localparam logic [W-1:0] LAST = W'(MOD - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (cen) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign sync_ovf = cen && (count_q == LAST);

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port synchronous framebuffer RAM between display
// scanout, a host command port and a clear engine. One access per cycle,
// fixed priority display > host > clear. All mem_* outputs are registered;
// read data comes back through a 2-stage source-tag pipeline.
//   clk, rst                     : clock, synchronous active-high reset
//   disp_req/disp_addr           : scanout read, returned 3 cycles later
//   disp_rvalid/disp_rdata       : scanout read return
//   host_valid/ready/we/addr/wdata : host command handshake
//   host_rvalid/host_rdata       : host read return
//   clr_start/clr_value/clr_busy : fill whole framebuffer with clr_value
//   mem_en/we/addr/wdata, mem_rdata : RAM port (1-cycle read latency)
//   host_stall                   : host has waited STARVE_LIM cycles or more
module vga_fb_arbiter
    import vga_pkg::*;
#(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int STARVE_LIM = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              host_stall
);

    localparam int              CNT_W      = $clog2(STARVE_LIM) + 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIM);

    host_state_e       host_state_q, host_state_d;
    logic              hcmd_we_q, hcmd_we_d;
    logic [ADDR_W-1:0] hcmd_addr_q, hcmd_addr_d;
    logic [DATA_W-1:0] hcmd_wdata_q, hcmd_wdata_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic              clr_busy_q, clr_busy_d;
    logic [DATA_W-1:0] clr_value_q, clr_value_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    ret_tag_e          tag1_q, tag1_d;
    ret_tag_e          tag2_q, tag2_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic              host_rvalid_q, host_rvalid_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    ret_tag_e          grant;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_ovf;
    logic              host_accept;

    // Display needs no handshake; a held host command is pending only in H_WAIT.
    assign grant       = pick_source(disp_req, host_state_q == H_WAIT, clr_busy_q);
    assign host_ready  = (host_state_q == H_IDLE) && !rst;
    assign host_accept = host_valid && host_ready;

    vga_fb_arbiter_mod_counter #(
        .MOD (1 << ADDR_W),
        .W   (ADDR_W)
    ) u_clr_cnt (
        .clk      (clk),
        .rst      (rst),
        .cen      (grant == TAG_CLR),
        .count    (clr_addr),
        .sync_ovf (clr_ovf)
    );

    always_comb begin
        host_state_d  = host_state_q;
        hcmd_we_d     = hcmd_we_q;
        hcmd_addr_d   = hcmd_addr_q;
        hcmd_wdata_d  = hcmd_wdata_q;
        wait_cnt_d    = wait_cnt_q;
        clr_busy_d    = clr_busy_q;
        clr_value_d   = clr_value_q;
        mem_en_d      = 1'b0;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        tag1_d        = grant;
        tag2_d        = tag1_q;
        disp_rvalid_d = (tag2_q == TAG_DISP);
        disp_rdata_d  = disp_rdata_q;
        host_rvalid_d = (tag2_q == TAG_HOST);
        host_rdata_d  = host_rdata_q;

        // RAM data for the access issued two cycles ago is on mem_rdata now.
        if (tag2_q == TAG_DISP) disp_rdata_d = mem_rdata;
        if (tag2_q == TAG_HOST) host_rdata_d = mem_rdata;

        case (grant)
            TAG_DISP: begin
                mem_en_d   = 1'b1;
                mem_addr_d = disp_addr;
            end
            TAG_HOST: begin
                mem_en_d    = 1'b1;
                mem_we_d    = hcmd_we_q;
                mem_addr_d  = hcmd_addr_q;
                mem_wdata_d = hcmd_wdata_q;
                // Host writes produce no return, so they must not tag the pipe.
                if (hcmd_we_q) tag1_d = TAG_NONE;
            end
            TAG_CLR: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = clr_addr;
                mem_wdata_d = clr_value_q;
            end
            default: ;
        endcase

        case (host_state_q)
            H_IDLE: begin
                if (host_accept) begin
                    hcmd_we_d    = host_we;
                    hcmd_addr_d  = host_addr;
                    hcmd_wdata_d = host_wdata;
                    host_state_d = H_WAIT;
                end
            end
            H_WAIT: begin
                if (grant == TAG_HOST) begin
                    wait_cnt_d   = '0;
                    host_state_d = hcmd_we_q ? H_IDLE : H_RET;
                end else if (wait_cnt_q != '1) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            H_RET: begin
                if (host_rvalid_q) host_state_d = H_IDLE;
            end
            default: host_state_d = H_IDLE;
        endcase

        // Clear runs from address 0 upward; a start request while busy is dropped.
        if (!clr_busy_q && clr_start) begin
            clr_busy_d  = 1'b1;
            clr_value_d = clr_value;
        end else if (clr_ovf) begin
            clr_busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            host_state_q  <= H_IDLE;
            hcmd_we_q     <= 1'b0;
            hcmd_addr_q   <= '0;
            hcmd_wdata_q  <= '0;
            wait_cnt_q    <= '0;
            clr_busy_q    <= 1'b0;
            clr_value_q   <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            tag1_q        <= TAG_NONE;
            tag2_q        <= TAG_NONE;
            disp_rvalid_q <= 1'b0;
            disp_rdata_q  <= '0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
        end else begin
            host_state_q  <= host_state_d;
            hcmd_we_q     <= hcmd_we_d;
            hcmd_addr_q   <= hcmd_addr_d;
            hcmd_wdata_q  <= hcmd_wdata_d;
            wait_cnt_q    <= wait_cnt_d;
            clr_busy_q    <= clr_busy_d;
            clr_value_q   <= clr_value_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag2_d;
            disp_rvalid_q <= disp_rvalid_d;
            disp_rdata_q  <= disp_rdata_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
        end
    end

    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign disp_rvalid = disp_rvalid_q;
    assign disp_rdata  = disp_rdata_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign clr_busy    = clr_busy_q;
    assign host_stall  = (wait_cnt_q >= STARVE_MAX);

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Directed bench for vga_fb_arbiter. Two instances share all inputs:
// dut (ADDR_W=8) for the traffic tests and dut_s (ADDR_W=4) for a short
// full clear. Each has its own 1-cycle-latency RAM model.
module tb_vga_fb_arbiter;

    logic       clk;
    logic       rst;
    logic       ram_load;
    logic       disp_req;
    logic [7:0] disp_addr;
    logic       host_valid;
    logic       host_we;
    logic [7:0] host_addr;
    logic [7:0] host_wdata;
    logic       clr_start;
    logic [7:0] clr_value;

    logic       disp_rvalid, host_ready, host_rvalid, clr_busy, host_stall;
    logic       mem_en, mem_we;
    logic [7:0] disp_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

    logic       disp_rvalid_s, host_ready_s, host_rvalid_s, clr_busy_s, host_stall_s;
    logic       mem_en_s, mem_we_s;
    logic [7:0] disp_rdata_s, host_rdata_s, mem_wdata_s, mem_rdata_s;
    logic [3:0] mem_addr_s;

    logic [7:0] ram   [0:255];
    logic [7:0] ram_s [0:15];

    int total = 0;
    int bad   = 0;

    typedef enum logic [1:0] {K_DREAD, K_HWRITE, K_HREAD} kind_e;
    typedef struct {
        kind_e      kind;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    vga_fb_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_LIM(16)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .host_valid(host_valid), .host_ready(host_ready), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .host_stall(host_stall)
    );

    vga_fb_arbiter #(.ADDR_W(4), .DATA_W(8), .STARVE_LIM(16)) dut_s (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr[3:0]),
        .disp_rvalid(disp_rvalid_s), .disp_rdata(disp_rdata_s),
        .host_valid(host_valid), .host_ready(host_ready_s), .host_we(host_we),
        .host_addr(host_addr[3:0]), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid_s), .host_rdata(host_rdata_s),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy_s),
        .mem_en(mem_en_s), .mem_we(mem_we_s), .mem_addr(mem_addr_s),
        .mem_wdata(mem_wdata_s), .mem_rdata(mem_rdata_s),
        .host_stall(host_stall_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] preload8(input int i);
        case (i)
            'h00:    return 8'h11;
            'h04:    return 8'h77;
            'h10:    return 8'hA5;
            'hFF:    return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 256; i++) ram[i] <= preload8(i);
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) ram_s[i] <= 8'h00;
        end else if (mem_en_s) begin
            if (mem_we_s) ram_s[mem_addr_s] <= mem_wdata_s;
            else          mem_rdata_s <= ram_s[mem_addr_s];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One uncontended transaction: check bus issue cycle and return timing.
    task automatic run_vec(input int idx, input vec_t v);
        logic is_host;
        logic is_read;
        is_host = (v.kind != K_DREAD);
        is_read = (v.kind != K_HWRITE);
        $display("vec %0d %s addr=0x%02h wdata=0x%02h exp=0x%02h",
                 idx, v.kind.name(), v.addr, v.wdata, v.exp_rdata);
        if (is_host) begin
            chk("v_ready_idle", 32'(host_ready), 32'd1);
            host_valid = 1'b1;
            host_we    = !is_read;
            host_addr  = v.addr;
            host_wdata = v.wdata;
        end else begin
            disp_req  = 1'b1;
            disp_addr = v.addr;
        end
        tick();
        disp_req   = 1'b0;
        host_valid = 1'b0;
        if (is_host) begin
            chk("v_ready_wait", 32'(host_ready), 32'd0);
            tick();
        end
        chk("v_mem_en", 32'(mem_en), 32'd1);
        chk("v_mem_we", 32'(mem_we), 32'(!is_read));
        chk("v_mem_addr", 32'(mem_addr), 32'(v.addr));
        if (!is_read) chk("v_mem_wdata", 32'(mem_wdata), 32'(v.wdata));
        tick();
        chk("v_rvalid_early", 32'(is_host ? host_rvalid : disp_rvalid), 32'd0);
        tick();
        chk("v_rvalid", 32'(is_host ? host_rvalid : disp_rvalid), 32'(is_read));
        if (is_read) chk("v_rdata", 32'(is_host ? host_rdata : disp_rdata), 32'(v.exp_rdata));
        tick();
        chk("v_rvalid_late", 32'(is_host ? host_rvalid : disp_rvalid), 32'd0);
        chk("v_ready_end", 32'(host_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{K_DREAD,  8'h10, 8'h00, 8'hA5};
        vecs[1] = '{K_DREAD,  8'hFF, 8'h00, 8'hC3};
        vecs[2] = '{K_HREAD,  8'h04, 8'h00, 8'h77};
        vecs[3] = '{K_HWRITE, 8'h30, 8'h96, 8'h00};
        vecs[4] = '{K_HREAD,  8'h30, 8'h00, 8'h96};
        vecs[5] = '{K_DREAD,  8'h30, 8'h00, 8'h96};
        vecs[6] = '{K_HWRITE, 8'h00, 8'hE7, 8'h00};
        vecs[7] = '{K_HREAD,  8'h00, 8'h00, 8'hE7};
        vecs[8] = '{K_DREAD,  8'h01, 8'h00, 8'h00};

        rst = 1'b1; ram_load = 1'b1;
        disp_req = 1'b0; disp_addr = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clr_start = 1'b0; clr_value = '0;

        // ---------------- reset state ----------------
        tick(); tick(); tick();
        $display("reset check");
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
        chk("rst_disp_rdata", 32'(disp_rdata), 32'd0);
        chk("rst_host_ready", 32'(host_ready), 32'd0);
        chk("rst_host_rvalid", 32'(host_rvalid), 32'd0);
        chk("rst_host_rdata", 32'(host_rdata), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd0);
        chk("rst_host_stall", 32'(host_stall), 32'd0);
        chk("rst_s_outs", 32'({disp_rvalid_s, host_ready_s, host_rvalid_s, clr_busy_s,
                              host_stall_s, mem_en_s, mem_we_s, mem_addr_s}), 32'd0);
        chk("rst_s_data", 32'({disp_rdata_s, host_rdata_s, mem_wdata_s}), 32'd0);
        rst = 1'b0; ram_load = 1'b0;
        #1;
        chk("rst_release_ready", 32'(host_ready), 32'd1);
        tick();

        // ---------------- table of uncontended transactions ----------------
        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
        tick();

        // ---------------- host write starved by display ----------------
        // Wait cycle k (0-based from the first H_WAIT cycle) shows count k,
        // so host_stall is expected from wait cycle 16 until the grant.
        $display("starve: host write 0x20=0x3C under continuous display");
        disp_req = 1'b1; disp_addr = 8'h10;
        host_valid = 1'b1; host_we = 1'b1; host_addr = 8'h20; host_wdata = 8'h3C;
        #1;
        chk("st_ready", 32'(host_ready), 32'd1);
        tick();
        host_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 19) disp_req = 1'b0;
            #1;
            chk("st_stall", 32'(host_stall), 32'(k >= 16));
            chk("st_ready_wait", 32'(host_ready), 32'd0);
            if (k == 18) begin
                chk("st_disp_busy_en", 32'(mem_en), 32'd1);
                chk("st_disp_busy_we", 32'(mem_we), 32'd0);
            end
            tick();
        end
        chk("st_wr_en", 32'(mem_en), 32'd1);
        chk("st_wr_we", 32'(mem_we), 32'd1);
        chk("st_wr_addr", 32'(mem_addr), 32'h20);
        chk("st_wr_data", 32'(mem_wdata), 32'h3C);
        chk("st_stall_clear", 32'(host_stall), 32'd0);
        tick();
        chk("st_ready_after", 32'(host_ready), 32'd1);
        chk("st_ram", 32'(ram[8'h20]), 32'h3C);
        tick(); tick(); tick();

        // ---------------- display every 5th cycle with a host read ----------------
        $display("interleave: display every 5th cycle, host read 0x04");
        for (int c = 0; c < 15; c++) begin
            disp_req   = (c % 5 == 0);
            disp_addr  = 8'h10;
            host_valid = (c == 4);
            host_we    = 1'b0;
            host_addr  = 8'h04;
            #1;
            if (c == 4) chk("il_ready", 32'(host_ready), 32'd1);
            if (c == 3) chk("il_disp0", 32'(disp_rvalid), 32'd1);
            if (c == 6) begin
                chk("il_d_en", 32'(mem_en), 32'd1);
                chk("il_d_addr", 32'(mem_addr), 32'h10);
            end
            if (c == 7) begin
                chk("il_h_en", 32'(mem_en), 32'd1);
                chk("il_h_we", 32'(mem_we), 32'd0);
                chk("il_h_addr", 32'(mem_addr), 32'h04);
            end
            if (c == 8) begin
                chk("il_d_rvalid", 32'(disp_rvalid), 32'd1);
                chk("il_d_rdata", 32'(disp_rdata), 32'hA5);
                chk("il_h_early", 32'(host_rvalid), 32'd0);
            end
            if (c == 9) begin
                chk("il_h_rvalid", 32'(host_rvalid), 32'd1);
                chk("il_h_rdata", 32'(host_rdata), 32'h77);
                chk("il_d_gap", 32'(disp_rvalid), 32'd0);
            end
            if (c == 10) chk("il_h_late", 32'(host_rvalid), 32'd0);
            if (c == 13) chk("il_disp2", 32'(disp_rvalid), 32'd1);
            tick();
        end
        disp_req = 1'b0; host_valid = 1'b0;
        tick(); tick();

        // ---------------- full clear on the 16-word instance ----------------
        $display("clear: ADDR_W=4 fill 0xFF, restart attempt ignored");
        for (int c = 0; c < 20; c++) begin
            clr_start = (c == 0) || (c == 5);
            clr_value = (c == 0) ? 8'hFF : 8'h11;
            #1;
            if (c >= 1) chk("cl_busy", 32'(clr_busy_s), 32'(c <= 16));
            if (c >= 2 && c <= 17) begin
                chk("cl_en", 32'(mem_en_s), 32'd1);
                chk("cl_we", 32'(mem_we_s), 32'd1);
                chk("cl_addr", 32'(mem_addr_s), 32'(c - 2));
                chk("cl_wdata", 32'(mem_wdata_s), 32'hFF);
            end
            if (c == 18) chk("cl_idle", 32'(mem_en_s), 32'd0);
            tick();
        end
        clr_start = 1'b0;
        begin
            int not_ff;
            not_ff = 0;
            for (int i = 0; i < 16; i++) if (ram_s[i] !== 8'hFF) not_ff++;
            chk("cl_ram_words_not_ff", 32'(not_ff), 32'd0);
        end

        // ---------------- reset during a host read and a clear ----------------
        // The ADDR_W=8 instance is still part-way through its 256-word clear.
        $display("mid-op reset: host read 0x04 in flight, clear running");
        host_valid = 1'b1; host_we = 1'b0; host_addr = 8'h04;
        #1;
        chk("mr_busy_before", 32'(clr_busy), 32'd1);
        chk("mr_ready", 32'(host_ready), 32'd1);
        tick();
        host_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mr_inflight_en", 32'(mem_en), 32'd1);
        chk("mr_inflight_addr", 32'(mem_addr), 32'h04);
        tick();
        chk("mr_rst_en", 32'(mem_en), 32'd0);
        chk("mr_rst_busy", 32'(clr_busy), 32'd0);
        chk("mr_rst_ready", 32'(host_ready), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("mr_release_ready", 32'(host_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk("mr_no_rvalid", 32'(host_rvalid), 32'd0);
            chk("mr_no_access", 32'(mem_en), 32'd0);
            chk("mr_no_busy", 32'(clr_busy), 32'd0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, framebuffer word-address width.
REQ-002 SHALL have parameter DATA_W, default 8, framebuffer word width.
REQ-003 SHALL have parameter STARVE_LIM, default 16, host wait cycles before host_stall asserts.
REQ-004 SHALL have port clk  in  1  single clock; one clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports disp_req in 1, disp_addr in ADDR_W: scanout read request, one word.
REQ-007 SHALL have ports disp_rvalid out 1, disp_rdata out DATA_W: scanout read return.
REQ-008 SHALL have ports host_valid in 1, host_ready out 1, host_we in 1, host_addr in ADDR_W, host_wdata in DATA_W: host command handshake.
REQ-009 SHALL have ports host_rvalid out 1, host_rdata out DATA_W: host read return.
REQ-010 SHALL have ports clr_start in 1, clr_value in DATA_W, clr_busy out 1: framebuffer clear engine.
REQ-011 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out DATA_W, mem_rdata in DATA_W: single-port synchronous RAM with 1-cycle read latency.
REQ-012 SHALL have port host_stall out 1: host wait reached STARVE_LIM.

Function
REQ-013 SHALL issue at most one memory access per cycle; all mem_* outputs registered.
REQ-014 SHALL use fixed priority display > host > clear, decided each cycle from pending requests.
REQ-015 SHALL sample disp_req/disp_addr at cycle t, drive mem_en=1, mem_we=0, mem_addr=disp_addr at t+1, and assert disp_rvalid for exactly one cycle at t+3 with disp_rdata = mem_rdata of t+2; latency fixed at 3, never stalled.
REQ-016 SHALL accept a host command on host_valid & host_ready; host FSM states H_IDLE (host_ready=1), H_WAIT (command held, host_ready=0), H_RET (read return pending).
REQ-017 H_IDLE -> H_WAIT on handshake; H_WAIT -> H_IDLE on grant of a write; H_WAIT -> H_RET on grant of a read; H_RET -> H_IDLE when host_rvalid pulses.
REQ-018 Host grant cycle SHALL be the first cycle after acceptance with no display access issued; host read data returns on host_rvalid 2 cycles after its mem_en.
REQ-019 SHALL count cycles in H_WAIT (saturating, clog2(STARVE_LIM)+1 bits); host_stall=1 while count >= STARVE_LIM; counter clears on host grant.
REQ-020 clr_start while clr_busy=0 SHALL latch clr_value, set clr_busy, and write clr_value to addresses 0..2^ADDR_W-1 in ascending order, one word per cycle granted to clear; clr_start while busy ignored.
REQ-021 clr_busy SHALL deassert the cycle after the write to address 2^ADDR_W-1 is issued; address counter wraps to 0.
REQ-022 A host write to an address not yet cleared SHALL be overwritten by the clear; documented, not prevented.
REQ-023 Simultaneous disp_req, host pending and clear pending: display issued, host and clear held unchanged.
REQ-024 Return-path tags SHALL be a 2-stage registered pipeline (source id: NONE/DISP/HOST/CLR) so returns never cross.

Reset
REQ-025 During rst: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, disp_rvalid=0, disp_rdata=0, host_ready=0, host_rvalid=0, host_rdata=0, clr_busy=0, host_stall=0, FSM=H_IDLE, pipeline tags NONE.
REQ-026 host_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-027 rst mid-operation SHALL discard held host command, in-flight returns and clear progress; no return pulse after reset.

Structure
REQ-028 Package vga_pkg SHALL hold host FSM state enum, return-tag enum (NONE, DISP, HOST, CLR) and priority constants.
REQ-029 Clear address counter SHALL be an instance of the codebase mod counter (MOD=2^ADDR_W, cen=clear grant, sync_ovf ends clear).

Verification
REQ-030 disp_req=1 addr=0x0010 at t, RAM[0x0010]=0xA5 -> mem_en at t+1, disp_rvalid=1 disp_rdata=0xA5 at t+3 only.
REQ-031 host write addr=0x0020 data=0x3C with disp_req high every cycle for 20 cycles -> host_stall=1 from wait cycle 16, write issued first free cycle, stall clears.
REQ-032 disp_req every 5th cycle, host read addr=0x0004 (RAM=0x77) -> host_rvalid=1 host_rdata=0x77, 2 cycles after its mem_en, display latency still 3.
REQ-033 ADDR_W=4, clr_start clr_value=0xFF, no other traffic -> 16 consecutive writes addr 0..15, clr_busy high 16 cycles, second clr_start mid-clear ignored.
REQ-034 rst asserted one cycle after host read accepted and during clear -> no host_rvalid, clr_busy=0, host_ready=1 the cycle after rst releases.
